rv32_pipe_stage_skid: RTL and testbench

Parametrised, elastic pipeline-stage register for the RV32 core, generalising the fixed inter-stage queues (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. It carries a configurable data payload, control bundle and instruction word from one stage to the next. It adds a valid/ready handshake, a two-entry skid buffer so backpressure never drops an instruction, and a synchronous flush. Empty slots present a bubble: the NOP instruction plus configurable safe control values.

---
 rtl/rv32_pipe_pkg.sv | 14 +
 rtl/rv32_pipe_slot.sv | 42 ++++
 rtl/rv32_pipe_stage_skid.sv | 155 +++++++++++++++
 tb/tb_rv32_pipe_stage_skid.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the RV32 elastic pipeline-stage register.
//   RV32_NOP     : instruction word presented by an empty stage (addi x0,x0,0)
//   pipe_state_t : stage fill level, encoded so the value equals the occupancy
package rv32_pipe_pkg;

    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/rv32_pipe_slot.sv
// Single load-enabled storage entry of a pipeline stage.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   load                          : capture the in_* fields on the next edge
//   in_data/in_ctrl/in_sel/in_code: values to capture
//   out_data/out_ctrl/out_sel/out_code: held values (bubble values after reset)
module rv32_pipe_slot
    import rv32_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = 128,
    parameter int unsigned       CTRL_W     = 6,
    parameter int unsigned       SEL_W      = 5,
    parameter logic [CTRL_W-1:0] RESET_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [31:0]       in_code,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [SEL_W-1:0]  out_sel,
    output logic [31:0]       out_code
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ctrl <= RESET_CTRL;
            out_sel  <= '0;
            out_code <= RV32_NOP;
        end else if (load) begin
            out_data <= in_data;
            out_ctrl <= in_ctrl;
            out_sel  <= in_sel;
            out_code <= in_code;
        end
    end

endmodule

// File: rtl/rv32_pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer and flush.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake (in_ready is registered)
//   in_data/ctrl/sel/code: incoming payload, control, register select, instruction
//   flush               : discard everything held and the incoming instruction
//   out_valid/out_ready : downstream handshake
//   out_data/ctrl/sel/code: MAIN entry when valid, bubble constants otherwise
//   occupancy           : number of entries held (0..2)
module rv32_pipe_stage_skid
    import rv32_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = 128,
    parameter int unsigned       CTRL_W      = 6,
    parameter int unsigned       SEL_W       = 5,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = 6'b000_01_1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [31:0]       in_code,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [SEL_W-1:0]  out_sel,
    output logic [31:0]       out_code,
    output logic [1:0]        occupancy
);

    pipe_state_t state, next_state;

    logic accept, pop;
    logic main_load, main_from_skid, skid_load;

    logic [DATA_W-1:0] main_in_data, main_data, skid_data;
    logic [CTRL_W-1:0] main_in_ctrl, main_ctrl, skid_ctrl;
    logic [SEL_W-1:0]  main_in_sel,  main_sel,  skid_sel;
    logic [31:0]       main_in_code, main_code, skid_code;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // State register; in_ready is registered from the next state so that it
    // never depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != TWO);
        end
    end

    // Next-state logic; flush wins over any accept in the same cycle.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) next_state = ONE;
                ONE: begin
                    if (accept && !pop)      next_state = TWO;
                    else if (pop && !accept) next_state = EMPTY;
                end
                TWO:   if (pop) next_state = ONE;
                default: next_state = EMPTY;
            endcase
        end
    end

    // Output / datapath-control logic.
    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        out_valid      = 1'b0;
        occupancy      = 2'd0;
        case (state)
            EMPTY: begin
                main_load = accept & ~flush;
            end
            ONE: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
                main_load = accept & pop & ~flush;
                skid_load = accept & ~pop & ~flush;
            end
            TWO: begin
                out_valid      = 1'b1;
                occupancy      = 2'd2;
                main_load      = pop & ~flush;
                main_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    assign main_in_data = main_from_skid ? skid_data : in_data;
    assign main_in_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_in_sel  = main_from_skid ? skid_sel  : in_sel;
    assign main_in_code = main_from_skid ? skid_code : in_code;

    rv32_pipe_slot #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .SEL_W     (SEL_W),
        .RESET_CTRL(BUBBLE_CTRL)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .in_data (main_in_data),
        .in_ctrl (main_in_ctrl),
        .in_sel  (main_in_sel),
        .in_code (main_in_code),
        .out_data(main_data),
        .out_ctrl(main_ctrl),
        .out_sel (main_sel),
        .out_code(main_code)
    );

    rv32_pipe_slot #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .SEL_W     (SEL_W),
        .RESET_CTRL(BUBBLE_CTRL)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .in_sel  (in_sel),
        .in_code (in_code),
        .out_data(skid_data),
        .out_ctrl(skid_ctrl),
        .out_sel (skid_sel),
        .out_code(skid_code)
    );

    // Stale MAIN contents are masked so an empty stage always shows a bubble.
    assign out_data = out_valid ? main_data : '0;
    assign out_ctrl = out_valid ? main_ctrl : BUBBLE_CTRL;
    assign out_sel  = out_valid ? main_sel  : '0;
    assign out_code = out_valid ? main_code : RV32_NOP;

endmodule

// File: tb/tb_rv32_pipe_stage_skid.sv
// Self-checking bench for rv32_pipe_stage_skid: a queue of expected entries
// is pushed on accept and popped on downstream transfer; the DUT outputs are
// compared against the queue head every cycle.
module tb_rv32_pipe_stage_skid;

    localparam int unsigned       DATA_W      = 128;
    localparam int unsigned       CTRL_W      = 6;
    localparam int unsigned       SEL_W       = 5;
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = 6'b000_01_1;
    localparam logic [31:0]       NOP         = 32'h0000_0013;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        logic [SEL_W-1:0]  s;
        logic [31:0]       code;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [SEL_W-1:0]  in_sel;
    logic [31:0]       in_code;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [SEL_W-1:0]  out_sel;
    logic [31:0]       out_code;
    logic [1:0]        occupancy;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rv32_pipe_stage_skid #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .SEL_W      (SEL_W),
        .BUBBLE_CTRL(BUBBLE_CTRL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_sel   (in_sel),
        .in_code  (in_code),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_sel  (out_sel),
        .out_code (out_code),
        .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = (q.size() != 0);
        chk("out_valid", 128'(out_valid), 128'(v));
        chk("in_ready",  128'(in_ready),  128'(q.size() != 2));
        chk("occupancy", 128'(occupancy), 128'(q.size()));
        chk("out_code",  128'(out_code),  128'(v ? q[0].code : NOP));
        chk("out_ctrl",  128'(out_ctrl),  128'(v ? q[0].c : BUBBLE_CTRL));
        chk("out_sel",   128'(out_sel),   128'(v ? q[0].s : '0));
        chk("out_data",  128'(out_data),  128'(v ? q[0].d : '0));
    endtask

    // Called at a negedge: drive inputs, model the edge, check at next negedge.
    task automatic cycle(input logic v, input logic [31:0] code, input logic fl, input logic ordy);
        ent_t        e;
        bit          acc, pp, hold;
        logic [31:0] prev_code;
        logic [DATA_W-1:0] prev_data;
        e.d    = {$urandom, $urandom, $urandom, $urandom};
        e.c    = CTRL_W'($urandom);
        e.s    = SEL_W'($urandom);
        e.code = code;
        in_valid  = v;
        in_data   = e.d;
        in_ctrl   = e.c;
        in_sel    = e.s;
        in_code   = e.code;
        flush     = fl;
        out_ready = ordy;
        hold      = rst_n && (q.size() != 0) && !ordy && !fl;
        prev_code = out_code;
        prev_data = out_data;
        @(posedge clk);
        acc = v && (q.size() != 2);
        pp  = (q.size() != 0) && ordy;
        if (!rst_n || fl) begin
            q.delete();
        end else begin
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
        check_outputs();
        if (hold) begin
            chk("stall_code", 128'(out_code), 128'(prev_code));
            chk("stall_data", 128'(out_data), 128'(prev_data));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        in_sel    = '0;
        in_code   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        chk("rst_code", 128'(out_code), 128'(32'h13));
        rst_n = 1'b1;

        // Streaming: codes 1..8 back to back, then drain.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 32'(i), 1'b0, 1'b1);
        chk("stream_last", 128'(out_code), 128'(32'h8));
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("stream_empty", 128'(out_valid), 128'(1'b0));

        // Backpressure with A, B, C.
        cycle(1'b1, 32'hA, 1'b0, 1'b1);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        chk("bp_occ2",   128'(occupancy), 128'(2'd2));
        chk("bp_rdy0",   128'(in_ready),  128'(1'b0));
        cycle(1'b1, 32'hC, 1'b0, 1'b0);
        chk("bp_holdA",  128'(out_code),  128'(32'hA));
        cycle(1'b1, 32'hC, 1'b0, 1'b1);
        chk("bp_relB",   128'(out_code),  128'(32'hB));
        chk("bp_rdy1",   128'(in_ready),  128'(1'b1));
        cycle(1'b1, 32'hC, 1'b0, 1'b1);
        chk("bp_C",      128'(out_code),  128'(32'hC));
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Flush while TWO with an incoming word.
        cycle(1'b1, 32'hD1, 1'b0, 1'b0);
        cycle(1'b1, 32'hD2, 1'b0, 1'b0);
        chk("fl_pre_occ", 128'(occupancy), 128'(2'd2));
        cycle(1'b1, 32'hDEAD, 1'b1, 1'b0);
        chk("fl_valid", 128'(out_valid), 128'(1'b0));
        chk("fl_occ",   128'(occupancy), 128'(2'd0));
        chk("fl_rdy",   128'(in_ready),  128'(1'b1));
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("fl_absent", 128'(out_valid), 128'(1'b0));

        // Simultaneous accept and pop in ONE.
        cycle(1'b1, 32'h111, 1'b0, 1'b1);
        cycle(1'b1, 32'h222, 1'b0, 1'b1);
        chk("ap_occ",  128'(occupancy), 128'(2'd1));
        chk("ap_code", 128'(out_code),  128'(32'h222));

        // Asynchronous reset mid-transfer.
        cycle(1'b1, 32'h333, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'(1'b0));
        chk("arst_code",  128'(out_code),  128'(32'h13));
        chk("arst_ctrl",  128'(out_ctrl),  128'(BUBBLE_CTRL));
        chk("arst_rdy",   128'(in_ready),  128'(1'b1));
        chk("arst_occ",   128'(occupancy), 128'(2'd0));
        q.delete();
        @(negedge clk);
        cycle(1'b1, 32'h444, 1'b0, 1'b1);
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 9) < 7, 32'(i) + 32'h1000,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
